counter_mode_sequencer: RTL and testbench

Programmable mode scheduler for the multimode counter. It holds a small table of segments, each a (mode, duration) pair, and plays them in order on the counter's 2-bit mode-select input. It can stop after one pass or loop. When idle it drives the counter's hold code, so the count freezes between programs. It sits between the host configuration pins and the counter's mode select.

---
 rtl/counter_mode_sequencer.sv | 96 +++++++++
 tb/tb_counter_mode_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mode_sequencer.sv
// rtl/counter_mode_sequencer.sv - segment table player driving the multimode counter's mode select
module counter_mode_sequencer #(
    parameter int NUM_SEG = 4,
    parameter int DUR_W   = 8,
    localparam int IW     = $clog2(NUM_SEG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_addr,
    input  logic [1:0]       cfg_mode,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic             cfg_last,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic [1:0]       mode_sel,
    output logic             busy,
    output logic [IW-1:0]    seg_idx,
    output logic             done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [0:0]       state;
    logic [DUR_W-1:0] remain;

    logic             tbl_last [NUM_SEG];
    logic [1:0]       tbl_mode [NUM_SEG];
    logic [DUR_W-1:0] tbl_dur  [NUM_SEG];

    logic             cur_last;
    logic [IW-1:0]    nxt_idx;

    // The top entry terminates the program even if its stored last bit is clear.
    assign cur_last = tbl_last[seg_idx] || (seg_idx == IW'(NUM_SEG - 1));
    assign nxt_idx  = seg_idx + IW'(1);
    assign busy     = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            seg_idx  <= '0;
            remain   <= '0;
            mode_sel <= MODE_HOLD;
            done     <= 1'b0;
            for (int i = 0; i < NUM_SEG; i++) begin
                tbl_last[i] <= 1'b1;
                tbl_mode[i] <= MODE_HOLD;
                tbl_dur[i]  <= '0;
            end
        end else begin
            done <= 1'b0;
            if (cfg_we && state == ST_IDLE) begin
                tbl_last[cfg_addr] <= cfg_last;
                tbl_mode[cfg_addr] <= cfg_mode;
                tbl_dur[cfg_addr]  <= cfg_dur;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state    <= ST_RUN;
                        seg_idx  <= '0;
                        remain   <= tbl_dur[0];
                        mode_sel <= tbl_mode[0];
                    end
                end
                default: begin
                    if (stop) begin
                        state    <= ST_IDLE;
                        seg_idx  <= '0;
                        mode_sel <= MODE_HOLD;
                    end else if (remain != '0) begin
                        remain <= remain - DUR_W'(1);
                    end else if (!cur_last) begin
                        seg_idx  <= nxt_idx;
                        remain   <= tbl_dur[nxt_idx];
                        mode_sel <= tbl_mode[nxt_idx];
                    end else if (loop_en) begin
                        seg_idx  <= '0;
                        remain   <= tbl_dur[0];
                        mode_sel <= tbl_mode[0];
                    end else begin
                        state    <= ST_IDLE;
                        seg_idx  <= '0;
                        mode_sel <= MODE_HOLD;
                        done     <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_mode_sequencer.sv
// tb/tb_counter_mode_sequencer.sv - directed-vector bench for counter_mode_sequencer
module tb_counter_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_dur = '0;
    logic       cfg_last = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [1:0] mode_sel;
    logic       busy;
    logic [1:0] seg_idx;
    logic       done;

    int checks = 0;
    int errors = 0;

    counter_mode_sequencer #(.NUM_SEG(4), .DUR_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mode(cfg_mode), .cfg_dur(cfg_dur), .cfg_last(cfg_last),
        .start(start), .stop(stop), .loop_en(loop_en),
        .mode_sel(mode_sel), .busy(busy), .seg_idx(seg_idx), .done(done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [1:0] m,
                               input logic [7:0] d, input logic l);
        cfg_addr = a; cfg_mode = m; cfg_dur = d; cfg_last = l; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({mode_sel, busy, seg_idx, done} !== {2'b11, 1'b0, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got mode=%b busy=%b seg=%0d done=%b, want 11 0 0 0",
                     mode_sel, busy, seg_idx, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({mode_sel, busy, done} !== {2'b11, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL default_run: got mode=%b busy=%b done=%b, want 11 1 0", mode_sel, busy, done);
        end
        step();
        checks++;
        if ({mode_sel, busy, done} !== {2'b11, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL default_done: got mode=%b busy=%b done=%b, want 11 0 1", mode_sel, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL default_done_clear: got done=%b, want 0", done);
        end
    endtask

    task automatic test_two_segment();
        logic [1:0] em;
        write_entry(2'd0, 2'b00, 8'd3, 1'b0);
        write_entry(2'd1, 2'b01, 8'd1, 1'b1);
        loop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            em = (i < 4) ? 2'b00 : 2'b01;
            checks++;
            if ({mode_sel, seg_idx, busy, done} !== {em, (i < 4) ? 2'd0 : 2'd1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL two_seg cycle %0d: got mode=%b seg=%0d busy=%b done=%b, want mode=%b",
                         i, mode_sel, seg_idx, busy, done, em);
            end
            step();
        end
        checks++;
        if ({mode_sel, busy, seg_idx, done} !== {2'b11, 1'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL two_seg_done: got mode=%b busy=%b seg=%0d done=%b, want 11 0 0 1",
                     mode_sel, busy, seg_idx, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL two_seg_done_pulse: got done=%b, want 0", done);
        end
    endtask

    task automatic test_loop();
        logic [1:0] em;
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 18) loop_en = 1'b0;
            em = ((i % 6) < 4) ? 2'b00 : 2'b01;
            checks++;
            if ({mode_sel, busy, done} !== {em, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL loop cycle %0d: got mode=%b busy=%b done=%b, want %b 1 0",
                         i, mode_sel, busy, done, em);
            end
            step();
        end
        checks++;
        if ({mode_sel, busy, done} !== {2'b11, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL loop_exit: got mode=%b busy=%b done=%b, want 11 0 1", mode_sel, busy, done);
        end
        step();
    endtask

    task automatic test_abort();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if ({mode_sel, seg_idx, busy} !== {2'b00, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_pre: got mode=%b seg=%0d busy=%b, want 00 0 1", mode_sel, seg_idx, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({mode_sel, busy, done} !== {2'b11, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_stop: got mode=%b busy=%b done=%b, want 11 0 0", mode_sel, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done=%b, want 0", done);
        end
        start = 1'b1;
        stop = 1'b1;
        step();
        step();
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if ({mode_sel, busy} !== {2'b11, 1'b0}) begin
            errors++;
            $display("FAIL start_stop_idle: got mode=%b busy=%b, want 11 0", mode_sel, busy);
        end
    endtask

    task automatic test_write_block();
        logic [1:0] em;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_addr = 2'd1; cfg_mode = 2'b10; cfg_dur = 8'd0; cfg_last = 1'b1; cfg_we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            em = (i < 4) ? 2'b00 : 2'b01;
            checks++;
            if ({mode_sel, busy} !== {em, 1'b1}) begin
                errors++;
                $display("FAIL blocked_write cycle %0d: got mode=%b busy=%b, want %b 1", i, mode_sel, busy, em);
            end
            step();
            cfg_we = 1'b0;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL blocked_write_done: got done=%b, want 1", done);
        end
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            em = (i < 4) ? 2'b00 : 2'b10;
            checks++;
            if ({mode_sel, busy} !== {em, 1'b1}) begin
                errors++;
                $display("FAIL idle_write cycle %0d: got mode=%b busy=%b, want %b 1", i, mode_sel, busy, em);
            end
            step();
        end
        checks++;
        if ({busy, done} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL idle_write_done: got busy=%b done=%b, want 0 1", busy, done);
        end
        step();
    endtask

    task automatic test_no_last();
        logic [1:0] modes [4];
        modes[0] = 2'b00; modes[1] = 2'b01; modes[2] = 2'b10; modes[3] = 2'b00;
        for (int i = 0; i < 4; i++) write_entry(2'(i), modes[i], 8'd0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mode_sel, seg_idx, busy} !== {modes[i], 2'(i), 1'b1}) begin
                errors++;
                $display("FAIL no_last seg %0d: got mode=%b seg=%0d busy=%b, want %b %0d 1",
                         i, mode_sel, seg_idx, busy, modes[i], i);
            end
            step();
        end
        checks++;
        if ({mode_sel, busy, done} !== {2'b11, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL no_last_done: got mode=%b busy=%b done=%b, want 11 0 1", mode_sel, busy, done);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({seg_idx, busy} !== {2'd1, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: got seg=%0d busy=%b, want 1 1", seg_idx, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({mode_sel, busy, seg_idx, done} !== {2'b11, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got mode=%b busy=%b seg=%0d done=%b, want 11 0 0 0",
                     mode_sel, busy, seg_idx, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({mode_sel, busy} !== {2'b11, 1'b1}) begin
            errors++;
            $display("FAIL table_cleared_run: got mode=%b busy=%b, want 11 1", mode_sel, busy);
        end
        step();
        checks++;
        if ({busy, done} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL table_cleared_done: got busy=%b done=%b, want 0 1", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_two_segment();
        test_loop();
        test_abort();
        test_write_block();
        test_no_last();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
